// File: rtl/xbar_master_req_buffer_if.sv
// Crossbar master-port bundle: the req/gnt request channel and the response channel.
// The buffer drives the request side through the master modport; the bridge uses slave.
interface xbar_master_req_buffer_if;
  logic        data_req;
  logic [31:0] data_add;
  logic        data_wen;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic [7:0]  data_aux;
  logic        data_gnt;
  logic        data_r_valid;
  logic [31:0] data_r_rdata;
  logic [7:0]  data_r_opc;
  logic [7:0]  data_r_aux;

  modport master (
    output data_req, data_add, data_wen, data_wdata, data_be, data_aux,
    input  data_gnt, data_r_valid, data_r_rdata, data_r_opc, data_r_aux
  );

  modport slave (
    input  data_req, data_add, data_wen, data_wdata, data_be, data_aux,
    output data_gnt, data_r_valid, data_r_rdata, data_r_opc, data_r_aux
  );
endinterface

// File: rtl/xbar_master_req_buffer.sv
// Per-master request FIFO with outstanding-credit cap and registered response return.
// Define XBAR_REQ_BUF_STATS_EN to add grant and stall statistics counters.
module xbar_master_req_buffer #(
  parameter  int DEPTH           = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 core_req_valid_i,
  output logic                 core_req_ready_o,
  input  logic [31:0]          core_add_i,
  input  logic                 core_wen_i,
  input  logic [31:0]          core_wdata_i,
  input  logic [3:0]           core_be_i,
  input  logic [7:0]           core_aux_i,
  xbar_master_req_buffer_if.master xbar,
  output logic                 core_rsp_valid_o,
  output logic [31:0]          core_rsp_rdata_o,
  output logic [7:0]           core_rsp_opc_o,
  output logic [7:0]           core_rsp_aux_o,
  output logic [OW-1:0]        outstanding_o,
  output logic                 err_unexp_rsp_o
`ifdef XBAR_REQ_BUF_STATS_EN
  ,
  output logic [31:0]          stat_gnt_cnt_o,
  output logic [31:0]          stat_stall_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  aux;
  } req_t;

  req_t          mem [DEPTH];
  req_t          head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [OW-1:0] out_q, out_d;
  logic          err_q, err_set;

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign core_req_ready_o = !full;
  assign push             = core_req_valid_i && !full;
  assign xbar.data_req    = !empty && (out_q < OW'(MAX_OUTSTANDING));
  assign pop              = xbar.data_req && xbar.data_gnt;

  // Head is read straight from the storage registers; it only moves on a pop.
  assign head             = mem[rd_ptr[AW-1:0]];
  assign xbar.data_add    = head.add;
  assign xbar.data_wen    = head.wen;
  assign xbar.data_wdata  = head.wdata;
  assign xbar.data_be     = head.be;
  assign xbar.data_aux    = head.aux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= '{add: core_add_i, wen: core_wen_i, wdata: core_wdata_i,
                                 be: core_be_i, aux: core_aux_i};
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // A response with nothing outstanding is flagged and leaves the count at zero.
  always_comb begin
    out_d   = out_q;
    err_set = 1'b0;
    if (xbar.data_r_valid && out_q == '0)
      err_set = 1'b1;
    else if (pop && !xbar.data_r_valid)
      out_d = out_q + OW'(1);
    else if (!pop && xbar.data_r_valid)
      out_d = out_q - OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign outstanding_o   = out_q;
  assign err_unexp_rsp_o = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rsp_valid_o <= 1'b0;
      core_rsp_rdata_o <= '0;
      core_rsp_opc_o   <= '0;
      core_rsp_aux_o   <= '0;
    end else begin
      core_rsp_valid_o <= xbar.data_r_valid;
      if (xbar.data_r_valid) begin
        core_rsp_rdata_o <= xbar.data_r_rdata;
        core_rsp_opc_o   <= xbar.data_r_opc;
        core_rsp_aux_o   <= xbar.data_r_aux;
      end
    end
  end

`ifdef XBAR_REQ_BUF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt_cnt_o   <= '0;
      stat_stall_cnt_o <= '0;
    end else begin
      if (pop) stat_gnt_cnt_o <= stat_gnt_cnt_o + 32'd1;
      if (xbar.data_req && !xbar.data_gnt) stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xbar_master_req_buffer.sv
// Scoreboard bench for xbar_master_req_buffer: request/response queues plus a credit model.
// Build with XBAR_REQ_BUF_STATS_EN defined to also cover the statistics counters.
module tb_xbar_master_req_buffer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 4;
  localparam int OW    = 3;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  aux;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [7:0]  opc;
    logic [7:0]  aux;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_req_valid;
  logic          core_req_ready;
  logic [31:0]   core_add;
  logic          core_wen;
  logic [31:0]   core_wdata;
  logic [3:0]    core_be;
  logic [7:0]    core_aux;
  logic          core_rsp_valid;
  logic [31:0]   core_rsp_rdata;
  logic [7:0]    core_rsp_opc;
  logic [7:0]    core_rsp_aux;
  logic [OW-1:0] outstanding;
  logic          err_unexp_rsp;
`ifdef XBAR_REQ_BUF_STATS_EN
  logic [31:0]   stat_gnt_cnt;
  logic [31:0]   stat_stall_cnt;
`endif

  xbar_master_req_buffer_if bus ();

  xbar_master_req_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .core_req_valid_i (core_req_valid),
    .core_req_ready_o (core_req_ready),
    .core_add_i       (core_add),
    .core_wen_i       (core_wen),
    .core_wdata_i     (core_wdata),
    .core_be_i        (core_be),
    .core_aux_i       (core_aux),
    .xbar             (bus),
    .core_rsp_valid_o (core_rsp_valid),
    .core_rsp_rdata_o (core_rsp_rdata),
    .core_rsp_opc_o   (core_rsp_opc),
    .core_rsp_aux_o   (core_rsp_aux),
    .outstanding_o    (outstanding),
    .err_unexp_rsp_o  (err_unexp_rsp)
`ifdef XBAR_REQ_BUF_STATS_EN
    ,
    .stat_gnt_cnt_o   (stat_gnt_cnt),
    .stat_stall_cnt_o (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   m_out    = 0;
  logic m_err    = 1'b0;
  logic m_rsp_pend = 1'b0;
  int   n_gnt    = 0;
  logic prev_stall = 1'b0;
  req_t prev_head;
  logic [31:0] m_gnt_cnt = '0;
  logic [31:0] m_stall_cnt = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model, sampled on the falling edge while inputs and state are settled.
  always @(negedge clk) begin
    req_t h, cur;
    rsp_t r;
    logic do_pop, rv;
    if (!rst_n) begin
      exp_req_q.delete();
      exp_rsp_q.delete();
      m_out = 0;
      m_err = 1'b0;
      m_rsp_pend = 1'b0;
      prev_stall = 1'b0;
      m_gnt_cnt = '0;
      m_stall_cnt = '0;
    end else begin
      cur = '{add: bus.data_add, wen: bus.data_wen, wdata: bus.data_wdata,
              be: bus.data_be, aux: bus.data_aux};
      check_eq("ready", 64'(core_req_ready), 64'(exp_req_q.size() < DEPTH));
      check_eq("data_req", 64'(bus.data_req), 64'(exp_req_q.size() > 0 && m_out < MAXO));
      check_eq("outstanding", 64'(outstanding), 64'(m_out));
      check_eq("err", 64'(err_unexp_rsp), 64'(m_err));
      check_eq("rsp_valid", 64'(core_rsp_valid), 64'(m_rsp_pend));
      if (core_rsp_valid && exp_rsp_q.size() > 0) begin
        r = exp_rsp_q.pop_front();
        check_eq("rsp_rdata", 64'(core_rsp_rdata), 64'(r.rdata));
        check_eq("rsp_opc", 64'(core_rsp_opc), 64'(r.opc));
        check_eq("rsp_aux", 64'(core_rsp_aux), 64'(r.aux));
      end
      if (prev_stall) begin
        check_eq("hold_req", 64'(bus.data_req), 64'(1));
        check_eq("hold_fields", 77'(cur) == 77'(prev_head) ? 64'(1) : 64'(0), 64'(1));
      end
`ifdef XBAR_REQ_BUF_STATS_EN
      check_eq("stat_gnt", 64'(stat_gnt_cnt), 64'(m_gnt_cnt));
      check_eq("stat_stall", 64'(stat_stall_cnt), 64'(m_stall_cnt));
`endif
      do_pop = bus.data_req && bus.data_gnt;
      rv     = bus.data_r_valid;
      if (do_pop && exp_req_q.size() > 0) begin
        h = exp_req_q.pop_front();
        check_eq("req_add", 64'(bus.data_add), 64'(h.add));
        check_eq("req_wen", 64'(bus.data_wen), 64'(h.wen));
        check_eq("req_wdata", 64'(bus.data_wdata), 64'(h.wdata));
        check_eq("req_be", 64'(bus.data_be), 64'(h.be));
        check_eq("req_aux", 64'(bus.data_aux), 64'(h.aux));
        n_gnt++;
      end
      if (core_req_valid && core_req_ready)
        exp_req_q.push_back('{add: core_add, wen: core_wen, wdata: core_wdata,
                              be: core_be, aux: core_aux});
      if (rv && m_out == 0) m_err = 1'b1;
      else if (do_pop && !rv) m_out++;
      else if (!do_pop && rv) m_out--;
      m_rsp_pend = rv;
      if (rv) exp_rsp_q.push_back('{rdata: bus.data_r_rdata, opc: bus.data_r_opc, aux: bus.data_r_aux});
      if (do_pop) m_gnt_cnt = m_gnt_cnt + 32'd1;
      if (bus.data_req && !bus.data_gnt) m_stall_cnt = m_stall_cnt + 32'd1;
      prev_stall = bus.data_req && !bus.data_gnt;
      prev_head  = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] add, input logic wen, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [7:0] aux);
    int n = 0;
    core_add = add; core_wen = wen; core_wdata = wdata; core_be = be; core_aux = aux;
    core_req_valid = 1'b1;
    while (!core_req_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("push_accept", 64'(core_req_ready), 64'(1));
    tick();
    core_req_valid = 1'b0;
  endtask

  task automatic push_rand();
    push_req($urandom, 1'($urandom), $urandom, 4'($urandom), 8'($urandom));
  endtask

  task automatic send_rsp(input logic [31:0] rdata, input logic [7:0] opc, input logic [7:0] aux);
    bus.data_r_valid = 1'b1;
    bus.data_r_rdata = rdata; bus.data_r_opc = opc; bus.data_r_aux = aux;
    tick();
    bus.data_r_valid = 1'b0;
  endtask

  task automatic wait_out(input int val);
    int n = 0;
    while (int'(outstanding) != val && n < 50) begin
      tick();
      n++;
    end
    check_eq("wait_out", 64'(outstanding), 64'(val));
  endtask

  task automatic drain();
    int n = 0;
    bus.data_gnt = 1'b1;
    while ((outstanding != '0 || bus.data_req) && n < 200) begin
      if (outstanding != '0) send_rsp($urandom, 8'($urandom), 8'($urandom));
      else tick();
      n++;
    end
    check_eq("drain_out", 64'(outstanding), 64'(0));
    check_eq("drain_req", 64'(bus.data_req), 64'(0));
    bus.data_gnt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int g0;
    logic [31:0] add_hold;
`ifdef XBAR_REQ_BUF_STATS_EN
    logic [31:0] s0;
`endif
    core_req_valid = 1'b0; core_add = '0; core_wen = 1'b0; core_wdata = '0;
    core_be = '0; core_aux = '0;
    bus.data_gnt = 1'b0; bus.data_r_valid = 1'b0;
    bus.data_r_rdata = '0; bus.data_r_opc = '0; bus.data_r_aux = '0;

    #2;
    check_eq("rst_ready", 64'(core_req_ready), 64'(1));
    check_eq("rst_req", 64'(bus.data_req), 64'(0));
    check_eq("rst_add", 64'(bus.data_add), 64'(0));
    check_eq("rst_out", 64'(outstanding), 64'(0));
    check_eq("rst_rspv", 64'(core_rsp_valid), 64'(0));
    check_eq("rst_err", 64'(err_unexp_rsp), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single load with grant in the request cycle
    bus.data_gnt = 1'b1;
    push_req(32'h1000_0004, 1'b1, 32'h0, 4'hF, 8'h11);
    check_eq("t1_latency", 64'(bus.data_req), 64'(1));
    check_eq("t1_add", 64'(bus.data_add), 64'(32'h1000_0004));
    tick();
    check_eq("t1_req_drop", 64'(bus.data_req), 64'(0));
    check_eq("t1_out1", 64'(outstanding), 64'(1));
    tick();
    send_rsp(32'hDEAD_BEEF, 8'h00, 8'h11);
    check_eq("t1_rspv", 64'(core_rsp_valid), 64'(1));
    check_eq("t1_rdata", 64'(core_rsp_rdata), 64'(32'hDEAD_BEEF));
    check_eq("t1_out0", 64'(outstanding), 64'(0));
    tick();
    check_eq("t1_rspv_low", 64'(core_rsp_valid), 64'(0));

    // Backpressure: fill the FIFO while the grant is held low
    bus.data_gnt = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_rand();
    check_eq("t2_full", 64'(core_req_ready), 64'(0));
    add_hold = bus.data_add;
`ifdef XBAR_REQ_BUF_STATS_EN
    s0 = stat_stall_cnt;
`endif
    repeat (5) tick();
    check_eq("t2_hold_add", 64'(bus.data_add), 64'(add_hold));
`ifdef XBAR_REQ_BUF_STATS_EN
    check_eq("t2_stall5", 64'(stat_stall_cnt - s0), 64'(5));
`endif
    // Full FIFO must refuse a push even while a pop happens that cycle
    core_add = 32'hCAFE_0001; core_wen = 1'b0; core_wdata = 32'h5A5A_5A5A;
    core_be = 4'h3; core_aux = 8'h77; core_req_valid = 1'b1;
    bus.data_gnt = 1'b1;
    tick();
    check_eq("t2_ready_after_pop", 64'(core_req_ready), 64'(1));
    tick();
    core_req_valid = 1'b0;
    drain();

    // Credit cap
    g0 = n_gnt;
    bus.data_gnt = 1'b1;
    for (int i = 0; i < 6; i++) push_rand();
    repeat (3) tick();
    check_eq("t3_gnts4", 64'(n_gnt - g0), 64'(4));
    check_eq("t3_req_off", 64'(bus.data_req), 64'(0));
    check_eq("t3_out4", 64'(outstanding), 64'(4));
    send_rsp($urandom, 8'h01, 8'h02);
    repeat (2) tick();
    check_eq("t3_gnts5", 64'(n_gnt - g0), 64'(5));
    check_eq("t3_out4b", 64'(outstanding), 64'(4));
    drain();

    // Grant and response in the same cycle at outstanding 2
    bus.data_gnt = 1'b1;
    push_rand(); push_rand();
    wait_out(2);
    bus.data_gnt = 1'b0;
    push_rand();
    check_eq("t4_pre", 64'(outstanding), 64'(2));
    bus.data_gnt = 1'b1;
    bus.data_r_valid = 1'b1; bus.data_r_rdata = 32'h1234_5678;
    bus.data_r_opc = 8'h0A; bus.data_r_aux = 8'h0B;
    tick();
    bus.data_gnt = 1'b0; bus.data_r_valid = 1'b0;
    check_eq("t4_same", 64'(outstanding), 64'(2));
    drain();

    // Unexpected response, then reset mid-burst
    send_rsp(32'hBAD0_0001, 8'h0C, 8'h0D);
    check_eq("t5_err", 64'(err_unexp_rsp), 64'(1));
    check_eq("t5_fwd", 64'(core_rsp_rdata), 64'(32'hBAD0_0001));
    check_eq("t5_out0", 64'(outstanding), 64'(0));
    bus.data_gnt = 1'b1;
    push_rand(); push_rand(); push_rand();
    bus.data_gnt = 1'b0;
    push_rand(); push_rand();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_ready", 64'(core_req_ready), 64'(1));
    check_eq("t5_rst_out", 64'(outstanding), 64'(0));
    check_eq("t5_rst_err", 64'(err_unexp_rsp), 64'(0));
    check_eq("t5_rst_req", 64'(bus.data_req), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    send_rsp(32'h0BAD_0002, 8'h0E, 8'h0F);
    check_eq("t5_post_err", 64'(err_unexp_rsp), 64'(1));
    check_eq("t5_post_out", 64'(outstanding), 64'(0));
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
